// File: rtl/bypass_adder_r_pkg.sv
// Shared defaults for the registered carry-skip adder.
//
// Contents:
//   DEF_WIDTH - default operand/sum width in bits
//   DEF_BLOCK - default bits per skip block (must divide the width)
package bypass_adder_r_pkg;

    localparam int DEF_WIDTH = 32;
    localparam int DEF_BLOCK = 4;

endpackage

// File: rtl/bypass_block.sv
// One carry-skip block: a BLOCK-bit ripple adder whose carry-out can bypass
// the ripple chain when every bit of the block propagates.
//
// Ports:
//   a, b  - BLOCK-bit operand slices
//   cin   - carry into the block
//   s     - BLOCK-bit sum slice
//   cout  - carry out of the block (skip mux output)
module bypass_block #(
    parameter int BLOCK = 4
) (
    input  logic [BLOCK-1:0] a,
    input  logic [BLOCK-1:0] b,
    input  logic             cin,
    output logic [BLOCK-1:0] s,
    output logic             cout
);

    logic [BLOCK-1:0] p;
    logic [BLOCK-1:0] g;
    logic [BLOCK:0]   c;
    logic             blk_p;

    always_comb begin
        p    = a ^ b;
        g    = a & b;
        s    = '0;
        c    = '0;
        c[0] = cin;
        for (int i = 0; i < BLOCK; i++) begin
            s[i]   = p[i] ^ c[i];
            c[i+1] = g[i] | (p[i] & c[i]);
        end
        blk_p = &p;
        // When all bits propagate the ripple carry-out equals cin anyway;
        // taking cin directly just shortens the critical path.
        cout  = blk_p ? cin : c[BLOCK];
    end

endmodule

// File: rtl/bypass_adder_r.sv
// Registered carry-skip adder: {Cout, Sum} = A + B + Cin, two-stage pipeline.
// Operands are registered, summed by a chain of bypass_block instances, and
// the result is registered. One result per clock, latency 2.
//
// Ports:
//   clk   - rising-edge clock
//   rst_n - asynchronous active-low reset, clears every register
//   A, B  - WIDTH-bit unsigned operands
//   Cin   - carry-in
//   Sum   - registered low WIDTH bits of A + B + Cin
//   Cout  - registered carry-out (unsigned overflow)
module bypass_adder_r
    import bypass_adder_r_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int BLOCK = DEF_BLOCK
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Cin,
    output logic [WIDTH-1:0] Sum,
    output logic             Cout
);

    localparam int NUM_BLOCKS = WIDTH / BLOCK;

    if (WIDTH < 1) begin : g_bad_width
        $error("bypass_adder_r: WIDTH must be >= 1");
    end
    if (BLOCK < 1 || (WIDTH % BLOCK) != 0) begin : g_bad_block
        $error("bypass_adder_r: WIDTH must be a multiple of BLOCK");
    end

    logic [WIDTH-1:0]  a_q;
    logic [WIDTH-1:0]  b_q;
    logic              cin_q;
    logic [WIDTH-1:0]  core_sum;
    logic [NUM_BLOCKS:0] carry;

    // Stage 1: operand capture.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q   <= '0;
            b_q   <= '0;
            cin_q <= 1'b0;
        end else begin
            a_q   <= A;
            b_q   <= B;
            cin_q <= Cin;
        end
    end

    assign carry[0] = cin_q;

    for (genvar k = 0; k < NUM_BLOCKS; k++) begin : g_blk
        bypass_block #(
            .BLOCK (BLOCK)
        ) u_blk (
            .a    (a_q[k*BLOCK +: BLOCK]),
            .b    (b_q[k*BLOCK +: BLOCK]),
            .cin  (carry[k]),
            .s    (core_sum[k*BLOCK +: BLOCK]),
            .cout (carry[k+1])
        );
    end

    // Stage 2: result capture.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            Sum  <= '0;
            Cout <= 1'b0;
        end else begin
            Sum  <= core_sum;
            Cout <= carry[NUM_BLOCKS];
        end
    end

endmodule

// File: tb/tb_bypass_adder_r.sv
// Scoreboard bench for bypass_adder_r: a 32/4 and a 16/8 instance share
// clock, reset and (low bits of) stimulus; expected sums are queued when
// driven and compared two cycles later.
module tb_bypass_adder_r;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic [31:0] a32 = '0;
    logic [31:0] b32 = '0;
    logic        cin = 1'b0;
    logic [31:0] sum32;
    logic        cout32;
    logic [15:0] sum16;
    logic        cout16;

    int checks = 0;
    int errors = 0;

    logic [32:0] q32[$];
    logic [16:0] q16[$];
    string       qtag[$];

    always #5 clk = ~clk;

    bypass_adder_r #(
        .WIDTH (32),
        .BLOCK (4)
    ) u_dut32 (
        .clk   (clk),
        .rst_n (rst_n),
        .A     (a32),
        .B     (b32),
        .Cin   (cin),
        .Sum   (sum32),
        .Cout  (cout32)
    );

    bypass_adder_r #(
        .WIDTH (16),
        .BLOCK (8)
    ) u_dut16 (
        .clk   (clk),
        .rst_n (rst_n),
        .A     (a32[15:0]),
        .B     (b32[15:0]),
        .Cin   (cin),
        .Sum   (sum16),
        .Cout  (cout16)
    );

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input string tag, input logic [31:0] a, input logic [31:0] b,
                         input logic c);
        a32 = a;
        b32 = b;
        cin = c;
        q32.push_back({1'b0, a} + {1'b0, b} + {32'd0, c});
        q16.push_back({1'b0, a[15:0]} + {1'b0, b[15:0]} + {16'd0, c});
        qtag.push_back(tag);
    endtask

    // Compare the result due now (if any), then drive the next operands.
    task automatic step(input string tag, input logic [31:0] a, input logic [31:0] b,
                        input logic c);
        logic [32:0] e32;
        logic [16:0] e16;
        string       t;
        @(negedge clk);
        if (q32.size() == 2) begin
            e32 = q32.pop_front();
            e16 = q16.pop_front();
            t   = qtag.pop_front();
            check_eq({t, "/w32"}, 64'({cout32, sum32}), 64'(e32));
            check_eq({t, "/w16"}, 64'({cout16, sum16}), 64'(e16));
        end
        drive(tag, a, b, c);
    endtask

    task automatic hold_reset(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            check_eq("rst_hold/w32", 64'({cout32, sum32}), 64'd0);
            check_eq("rst_hold/w16", 64'({cout16, sum16}), 64'd0);
            a32 = $urandom;
            b32 = $urandom;
            cin = 1'($urandom_range(0, 1));
        end
    endtask

    // Release reset and present A=1, B=1 as the first post-reset operands;
    // the cycle in between must still read 0.
    task automatic release_reset();
        @(negedge clk);
        rst_n = 1'b1;
        q32.delete();
        q16.delete();
        qtag.delete();
        q32.push_back(33'd0);
        q16.push_back(17'd0);
        qtag.push_back("post_rst_zero");
        drive("first_1p1", 32'd1, 32'd1, 1'b0);
    endtask

    typedef struct {
        string       tag;
        logic [31:0] a;
        logic [31:0] b;
        logic        c;
    } vec_t;

    vec_t dir[12];

    initial begin
        dir[0]  = '{"wrap_ff_p1",    32'hFFFFFFFF, 32'h00000001, 1'b0};
        dir[1]  = '{"skip_0_ff_c1",  32'h00000000, 32'hFFFFFFFF, 1'b1};
        dir[2]  = '{"skip_aa_55_c1", 32'hAAAAAAAA, 32'h55555555, 1'b1};
        dir[3]  = '{"prop_a5_5a",    32'hA5A5A5A5, 32'h5A5A5A5A, 1'b0};
        dir[4]  = '{"prop_0_ff",     32'h00000000, 32'hFFFFFFFF, 1'b0};
        dir[5]  = '{"mix_1234",      32'h12345678, 32'h87654321, 1'b1};
        dir[6]  = '{"mix_1111",      32'h11111111, 32'h22222222, 1'b1};
        dir[7]  = '{"ff_plus_ff",    32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0};
        dir[8]  = '{"msb_7f_p1",     32'h7FFFFFFF, 32'h00000001, 1'b0};
        dir[9]  = '{"msb_80_ff",     32'h80000000, 32'hFFFFFFFF, 1'b0};
        dir[10] = '{"five_5",        32'h00000005, 32'h00000005, 1'b0};
        dir[11] = '{"five_5b",       32'h00000005, 32'h00000005, 1'b0};

        #1 rst_n = 1'b0;
        hold_reset(4);
        release_reset();

        // Spot checks of directed vectors against known sums (32-bit instance).
        check_eq("known_1p1", 64'(q32[1]), 64'h2);
        for (int i = 0; i < 12; i++) step(dir[i].tag, dir[i].a, dir[i].b, dir[i].c);
        step("five_5c", 32'd5, 32'd5, 1'b0);
        step("five_5d", 32'd5, 32'd5, 1'b0);

        // Async reset mid-cycle: outputs are 10 here and must clear without a clock edge.
        @(posedge clk);
        #2;
        check_eq("pre_async/w32", 64'({cout32, sum32}), 64'd10);
        rst_n = 1'b0;
        #1;
        check_eq("async_clr/w32", 64'({cout32, sum32}), 64'd0);
        check_eq("async_clr/w16", 64'({cout16, sum16}), 64'd0);
        hold_reset(3);
        release_reset();

        for (int i = 0; i < 10000; i++) begin
            step("rand", $urandom, $urandom, 1'($urandom_range(0, 1)));
        end
        step("drain", 32'd0, 32'd0, 1'b0);
        step("drain", 32'd0, 32'd0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/bypass_adder_r.md
Name: bypass_adder_r

Overview:
- Registered carry-skip (bypass) adder: Sum/Cout = A + B + Cin over WIDTH bits.
- Datapath: WIDTH-bit carry-skip core, split into WIDTH/BLOCK ripple blocks, each with a skip mux.
- Input and output registers make it a 2-stage pipeline.
- Used as a timing-closed arithmetic primitive in the datapath; one result per clock.

Parameters:
- WIDTH, 32, operand/sum width in bits; must be >= 1.
- BLOCK, 4, bits per skip block; WIDTH % BLOCK must be 0. Violation is an elaboration-time error ($error in a generate check).

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- A  input  WIDTH  operand A, unsigned
- B  input  WIDTH  operand B, unsigned
- Cin  input  1  carry-in
- Sum  output  WIDTH  registered sum, low WIDTH bits of A+B+Cin
- Cout  output  1  registered carry-out, bit WIDTH of A+B+Cin

Behaviour:
- Reset: rst_n low clears all registers immediately, independent of clk. Clears input regs (a_q, b_q, cin_q), Sum and Cout, so Sum=0 and Cout=0 while reset is held. Release is synchronous in effect: the first capture happens on the first rising clk edge with rst_n high.
- Stage 1: on each rising clk edge, capture A, B, Cin into a_q, b_q, cin_q.
- Stage 2: on each rising clk edge, capture the combinational core result into Sum and Cout.
- Latency: 2 clocks from the input-capturing edge to valid output. No stalls, no enable, no handshake; one new result every cycle.
- Core: blocks k = 0 .. WIDTH/BLOCK-1.
  - c0 = cin_q.
  - Per bit: p_i = a_i ^ b_i, g_i = a_i & b_i.
  - Ripple within block: s_i = p_i ^ c_i; c_{i+1} = g_i | (p_i & c_i).
  - Block propagate P_k = AND of p_i over the block.
  - Block carry-out = P_k ? block carry-in : ripple carry-out.
  - Cout = carry-out of the last block.
- Arithmetic is purely unsigned modulo 2^WIDTH. Cout is the unsigned overflow; there is no signed-overflow output.
- Result must be bit-identical to {Cout,Sum} = A + B + Cin for all inputs. The skip path affects timing only, never function.
- Boundary cases:
  - All-propagate operands (e.g. A=~B) with Cin=1: carry skips every block; Sum=0, Cout=1.
  - Full wrap (all-ones + 1): Sum=0, Cout=1.
- Reset asserted mid-pipeline: in-flight results are discarded. After release, outputs show 0 until the first post-reset operands have traversed both stages.
- X on inputs must not reach outputs while rst_n is low.

Decomposition:
- No shared package is required. WIDTH/BLOCK defaults (32/4) may live as localparams in the project's common arithmetic package if one exists.
- One sub-module: bypass_block (parameter BLOCK). Ports: a, b, cin → s, cout.
  - Holds the ripple chain, the propagate AND and the skip mux.
  - Instantiated WIDTH/BLOCK times via generate and chained by carry.
- Top holds only the registers and the chain.

Test Plan:
- Reset: hold rst_n=0 with random A/B/Cin, toggling clk → Sum=0, Cout=0. Deassert, apply A=1, B=1, Cin=0 → 2 clocks later Sum=0x00000002, Cout=0.
- Carry wrap / full skip:
  - A=0xFFFFFFFF, B=0x00000001, Cin=0 → Sum=0, Cout=1.
  - A=0x00000000, B=0xFFFFFFFF, Cin=1 → Sum=0, Cout=1.
  - A=0xAAAAAAAA, B=0x55555555, Cin=1 → Sum=0, Cout=1.
- No-carry propagate: A=0xA5A5A5A5, B=0x5A5A5A5A, Cin=0 → Sum=0xFFFFFFFF, Cout=0. Same with A=0x00000000, B=0xFFFFFFFF, Cin=0.
- Mixed values:
  - A=0x12345678, B=0x87654321, Cin=1 → Sum=0x9999999A, Cout=0.
  - A=0x11111111, B=0x22222222, Cin=1 → Sum=0x33333334, Cout=0.
  - A=B=0xFFFFFFFF, Cin=0 → Sum=0xFFFFFFFE, Cout=1.
- MSB edges:
  - A=0x7FFFFFFF, B=1, Cin=0 → Sum=0x80000000, Cout=0.
  - A=0x80000000, B=0xFFFFFFFF, Cin=0 → Sum=0x7FFFFFFF, Cout=1.
- Pipelining and reset:
  - Back-to-back new operands every clock for 10k random vectors → each output matches the reference A+B+Cin from 2 cycles earlier.
  - Async reset pulse mid-stream → outputs drop to 0 without waiting for a clock edge.
  - Repeat the random run with WIDTH=16, BLOCK=8.
